// File: rtl/uart_cmd_sequencer_pkg.sv
// Shared definitions for the UART command sequencer: sync marker default,
// FSM state encodings, error counter width and the frame checksum.
package uart_cmd_sequencer_pkg;

    localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'h55;
    localparam int unsigned ERR_CNT_W         = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_ISSUE = 3'd4
    } state_t;

    function automatic logic [7:0] frame_chk(input logic [7:0] addr, input logic [7:0] data);
        return addr ^ data;
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_timeout_timer.sv
// Inter-byte timeout counter: counts while run is high, holds at the
// threshold, and flags expiry combinationally so the caller can register it.
module uart_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned      CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (run && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign expired = run && (r_cnt == LAST);

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses SYNC/ADDR/DATA/CHK byte frames from the UART receiver into single
// register-bus writes, with backpressure, timeout and checksum error reporting.
module uart_cmd_sequencer
    import uart_cmd_sequencer_pkg::*;
#(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 100,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 rx_enable,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [7:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 err_chk,
    output logic                 err_timeout,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_t r_state;
    state_t w_state_nxt;

    logic                 r_rx_enable;
    logic                 r_wr_valid;
    logic [7:0]           r_wr_addr;
    logic [7:0]           r_wr_data;
    logic                 r_err_chk;
    logic                 r_err_timeout;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic w_accept;
    logic w_expired;
    logic w_run;
    logic w_clear;
    logic w_lat_addr;
    logic w_lat_data;
    logic w_chk_err;
    logic w_to_err;

    assign w_accept = in_valid && r_rx_enable;
    assign w_run    = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CHK);
    // Any state change restarts the count, as does every accepted byte.
    assign w_clear  = w_accept || (w_state_nxt != r_state);

    uart_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .run    (w_run),
        .expired(w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lat_addr  = 1'b0;
        w_lat_data  = 1'b0;
        w_chk_err   = 1'b0;
        w_to_err    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (in_data == SYNC_BYTE)) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_accept) begin
                    w_lat_addr  = 1'b1;
                    w_state_nxt = ST_DATA;
                end else if (w_expired) begin
                    w_to_err    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_accept) begin
                    w_lat_data  = 1'b1;
                    w_state_nxt = ST_CHK;
                end else if (w_expired) begin
                    w_to_err    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (w_accept) begin
                    if (in_data == frame_chk(r_wr_addr, r_wr_data)) begin
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_chk_err   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_expired) begin
                    w_to_err    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (r_wr_valid && wr_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_enable   <= 1'b1;
            r_wr_valid    <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_err_chk     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_count   <= '0;
        end else begin
            r_rx_enable   <= (w_state_nxt != ST_ISSUE);
            r_wr_valid    <= (w_state_nxt == ST_ISSUE);
            r_err_chk     <= w_chk_err;
            r_err_timeout <= w_to_err;
            if (w_lat_addr) begin
                r_wr_addr <= in_data;
            end
            if (w_lat_data) begin
                r_wr_data <= in_data;
            end
            if ((w_chk_err || w_to_err) && (r_err_count != '1)) begin
                r_err_count <= r_err_count + ERR_CNT_W'(1);
            end
        end
    end

    assign rx_enable   = r_rx_enable;
    assign wr_valid    = r_wr_valid;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign err_chk     = r_err_chk;
    assign err_timeout = r_err_timeout;
    assign err_count   = r_err_count;

endmodule
